// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer
//    Captures one complete frame of CHANELS complex FFT bins in a single cycle
//    and streams them out one channel per beat over valid/ready, attaching the
//    squared magnitude, the channel index and a last flag. The upstream
//    accumulator cannot be stalled, so frames arriving while a stream is in
//    progress are dropped and counted.
//
// Ports
//    clk, rst        : clock, synchronous active-high reset
//    frame_valid_i   : one-cycle pulse, re_i/im_i hold a complete frame
//    re_i, im_i      : CHANELS signed bins, channel k at index k
//    out_valid/ready : output handshake
//    out_re, out_im  : bin of the current beat
//    out_pow         : out_re^2 + out_im^2, full precision, unsigned
//    out_ch          : channel index of the current beat
//    out_last        : current beat is channel CHANELS-1
//    busy            : a frame is held and not yet fully sent
//    drop_cnt        : saturating count of discarded frames
//    overflow        : sticky, at least one frame was discarded
module fft_bin_serializer #(
   parameter  int S_WIDTH    = 32,
   parameter  int CHANELS    = 2,
   parameter  int DROP_WIDTH = 16,
   localparam int P_WIDTH    = 2 * S_WIDTH + 1,
   localparam int CH_W       = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               frame_valid_i,
   input  logic [CHANELS-1:0][S_WIDTH-1:0]    re_i,
   input  logic [CHANELS-1:0][S_WIDTH-1:0]    im_i,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic signed [S_WIDTH-1:0]          out_re,
   output logic signed [S_WIDTH-1:0]          out_im,
   output logic [P_WIDTH-1:0]                 out_pow,
   output logic [CH_W-1:0]                    out_ch,
   output logic                               out_last,
   output logic                               busy,
   output logic [DROP_WIDTH-1:0]              drop_cnt,
   output logic                               overflow
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANELS - 1);

   state_t                           state;
   logic [CHANELS-1:0][S_WIDTH-1:0]  bank_re;
   logic [CHANELS-1:0][S_WIDTH-1:0]  bank_im;

   logic                             handshake;
   logic                             last_hs;
   logic                             accept;
   logic [CH_W-1:0]                  nxt_ch;
   logic [P_WIDTH-1:0]               cap_pow;
   logic [P_WIDTH-1:0]               nxt_pow;

   // Squares are non-negative, so each fits in 2*S_WIDTH bits; the extra
   // top bit of the sum holds the (-2^(S-1))^2 * 2 corner exactly.
   function automatic logic [P_WIDTH-1:0] pow_of(input logic signed [S_WIDTH-1:0] re,
                                                 input logic signed [S_WIDTH-1:0] im);
      logic signed [2*S_WIDTH-1:0] sq_re;
      logic signed [2*S_WIDTH-1:0] sq_im;
      sq_re = (2*S_WIDTH)'(re) * (2*S_WIDTH)'(re);
      sq_im = (2*S_WIDTH)'(im) * (2*S_WIDTH)'(im);
      return {1'b0, sq_re} + {1'b0, sq_im};
   endfunction

   assign handshake = out_valid && out_ready;
   assign last_hs   = handshake && (out_ch == LAST_CH);
   // A new frame is taken when idle, or when the final beat leaves in the
   // same cycle (back-to-back); any other pulse during SEND is a drop.
   assign accept    = frame_valid_i && ((state == IDLE) || last_hs);

   // NOTE: every variable gets a value on entry so no latch is inferred.
   always_comb begin
      nxt_ch  = out_ch + CH_W'(1);
      cap_pow = pow_of(re_i[0], im_i[0]);
      nxt_pow = '0;
      if (out_ch != LAST_CH)
         nxt_pow = pow_of(bank_re[nxt_ch], bank_im[nxt_ch]);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         // NOTE: the capture bank is reset too, so a stale frame can never
         // leak out after reset; it is small enough to live in flops.
         bank_re   <= '0;
         bank_im   <= '0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_pow   <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (accept) begin
            // Channel 0 goes straight from the input bus so the first beat
            // is visible one cycle after the pulse.
            bank_re   <= re_i;
            bank_im   <= im_i;
            out_re    <= re_i[0];
            out_im    <= im_i[0];
            out_pow   <= cap_pow;
            out_ch    <= '0;
            out_last  <= (CHANELS == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
         end else if (state == SEND && handshake) begin
            if (out_ch == LAST_CH) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end else begin
               out_re   <= bank_re[nxt_ch];
               out_im   <= bank_im[nxt_ch];
               out_pow  <= nxt_pow;
               out_ch   <= nxt_ch;
               out_last <= (nxt_ch == LAST_CH);
            end
         end

         if (frame_valid_i && !accept) begin
            overflow <= 1'b1;
            if (drop_cnt != {DROP_WIDTH{1'b1}})
               drop_cnt <= drop_cnt + DROP_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed bench for fft_bin_serializer with CHANELS=2, S_WIDTH=32 and a
// narrow drop counter so saturation is reachable in a few cycles.
module tb_fft_bin_serializer;

   localparam int S  = 32;
   localparam int CH = 2;
   localparam int DW = 4;
   localparam int PW = 2 * S + 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    frame_valid_i;
   logic [CH-1:0][S-1:0]    re_i;
   logic [CH-1:0][S-1:0]    im_i;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [S-1:0]     out_re;
   logic signed [S-1:0]     out_im;
   logic [PW-1:0]           out_pow;
   logic [0:0]              out_ch;
   logic                    out_last;
   logic                    busy;
   logic [DW-1:0]           drop_cnt;
   logic                    overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // {busy, out_valid, out_last, out_ch, out_re, out_im, out_pow}
   localparam int BW = 4 + 2 * S + PW;
   logic [BW-1:0] act;
   assign act = {busy, out_valid, out_last, out_ch, out_re, out_im, out_pow};

   fft_bin_serializer #(.S_WIDTH(S), .CHANELS(CH), .DROP_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .frame_valid_i(frame_valid_i),
      .re_i(re_i), .im_i(im_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_pow(out_pow),
      .out_ch(out_ch), .out_last(out_last), .busy(busy),
      .drop_cnt(drop_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Expected beat word built from hand-computed constants.
   function automatic logic [BW-1:0] beat(input logic last, input logic ch,
                                          input logic [S-1:0] re, input logic [S-1:0] im,
                                          input logic [PW-1:0] pow);
      return {1'b1, 1'b1, last, ch, re, im, pow};
   endfunction

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input logic [S-1:0] r0, input logic [S-1:0] i0,
                            input logic [S-1:0] r1, input logic [S-1:0] i1);
      re_i[0] = r0; im_i[0] = i0;
      re_i[1] = r1; im_i[1] = i1;
      frame_valid_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [BW+DW:0] exp_z;
      exp_z = '0;
      rst = 1'b1; frame_valid_i = 1'b0; out_ready = 1'b1;
      re_i = '0; im_i = '0;
      step();
      set_frame(32'd9, 32'd9, 32'd9, 32'd9);   // pulse during reset: ignored
      step();
      n_cmp++;
      if ({act, drop_cnt, overflow} !== exp_z) begin
         n_bad++;
         $display("FAIL reset_state: got %h expected %h", {act, drop_cnt, overflow}, exp_z);
      end
      frame_valid_i = 1'b0; rst = 1'b0;
      step();
      n_cmp++;
      if ({act, drop_cnt, overflow} !== exp_z) begin
         n_bad++;
         $display("FAIL reset_pulse_ignored: got %h expected %h", {act, drop_cnt, overflow}, exp_z);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      set_frame(32'd3, 32'd4, -32'sd4, 32'd5);
      step();
      frame_valid_i = 1'b0;
      re_i = '1; im_i = '1;   // bus may change after the pulse
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd3, 32'd4, 65'd25)) begin
         n_bad++;
         $display("FAIL basic_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd3, 32'd4, 65'd25));
      end
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd5, 65'd41)) begin
         n_bad++;
         $display("FAIL basic_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd5, 65'd41));
      end
      step();
      n_cmp++;
      if ({busy, out_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_idle: got busy/valid %b expected 00", {busy, out_valid});
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_frame(32'd7, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF, 65'd50)) begin
         n_bad++;
         $display("FAIL bp_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF, 65'd50));
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (act !== beat(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF, 65'd50)) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got %h expected %h", i, act, beat(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF, 65'd50));
         end
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFE, 65'd4)) begin
         n_bad++;
         $display("FAIL bp_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFE, 65'd4));
      end
      step();
      n_cmp++;
      if ({busy, out_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL bp_two_beats: got busy/valid %b expected 00", {busy, out_valid});
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      set_frame(32'd1, 32'd2, 32'd3, 32'd4);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd1, 32'd2, 65'd5)) begin
         n_bad++;
         $display("FAIL b2b_a_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd1, 32'd2, 65'd5));
      end
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'd3, 32'd4, 65'd25)) begin
         n_bad++;
         $display("FAIL b2b_a_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'd3, 32'd4, 65'd25));
      end
      // Second pulse coincides with the ch1 handshake.
      set_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 65'd2)) begin
         n_bad++;
         $display("FAIL b2b_b_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 65'd2));
      end
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'd2, 32'hFFFF_FFFD, 65'd13)) begin
         n_bad++;
         $display("FAIL b2b_b_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'd2, 32'hFFFF_FFFD, 65'd13));
      end
      step();
      n_cmp++;
      if ({busy, out_valid, drop_cnt, overflow} !== {2'b00, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_no_drop: got busy/valid/drop/ovf %b expected 0000000", {busy, out_valid, drop_cnt, overflow});
      end
   endtask

   task automatic test_drop();
      out_ready = 1'b0;
      set_frame(32'd10, 32'd0, 32'd0, 32'd10);
      step();
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd10, 32'd0, 65'd100)) begin
         n_bad++;
         $display("FAIL drop_c_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd10, 32'd0, 65'd100));
      end
      set_frame(32'd99, 32'd98, 32'd97, 32'd96);   // arrives while ch0 pending
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if ({drop_cnt, overflow} !== {4'd1, 1'b1}) begin
         n_bad++;
         $display("FAIL drop_count: got drop/ovf %h expected 3", {drop_cnt, overflow});
      end
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd10, 32'd0, 65'd100)) begin
         n_bad++;
         $display("FAIL drop_stream_kept: got %h expected %h", act, beat(1'b0, 1'b0, 32'd10, 32'd0, 65'd100));
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'd0, 32'd10, 65'd100)) begin
         n_bad++;
         $display("FAIL drop_c_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'd0, 32'd10, 65'd100));
      end
      // Pulse on the last channel while stalled is a drop as well.
      out_ready = 1'b0;
      set_frame(32'd50, 32'd50, 32'd50, 32'd50);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if ({drop_cnt, act} !== {4'd2, beat(1'b1, 1'b1, 32'd0, 32'd10, 65'd100)}) begin
         n_bad++;
         $display("FAIL drop_last_stalled: got %h expected %h", {drop_cnt, act}, {4'd2, beat(1'b1, 1'b1, 32'd0, 32'd10, 65'd100)});
      end
      out_ready = 1'b1;
      step();
      // Saturation: capture frame E, then 20 further pulses all drop.
      out_ready = 1'b0;
      set_frame(32'd6, 32'd8, 32'd1, 32'd1);
      step();
      for (int i = 0; i < 20; i++) step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if ({drop_cnt, overflow} !== {4'd15, 1'b1}) begin
         n_bad++;
         $display("FAIL drop_saturate: got drop/ovf %h expected 1f", {drop_cnt, overflow});
      end
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd6, 32'd8, 65'd100)) begin
         n_bad++;
         $display("FAIL drop_e_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd6, 32'd8, 65'd100));
      end
      out_ready = 1'b1;
      step();
      step();
      n_cmp++;
      if ({busy, out_valid, drop_cnt} !== {2'b00, 4'd15}) begin
         n_bad++;
         $display("FAIL drop_drain: got busy/valid/drop %h expected 0f", {busy, out_valid, drop_cnt});
      end
   endtask

   task automatic test_extremes();
      logic [PW-1:0] p_min;
      logic [PW-1:0] p_max;
      p_min = 65'h0_8000_0000_0000_0000;   // 2^63
      p_max = 65'h0_3FFF_FFFF_0000_0001;   // (2^31-1)^2
      out_ready = 1'b1;
      set_frame(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, p_min)) begin
         n_bad++;
         $display("FAIL ext_most_negative: got %h expected %h", act, beat(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, p_min));
      end
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd0, p_max)) begin
         n_bad++;
         $display("FAIL ext_most_positive: got %h expected %h", act, beat(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd0, p_max));
      end
      step();
   endtask

   task automatic test_reset_midstream();
      logic [BW+DW:0] exp_z;
      exp_z = '0;
      out_ready = 1'b1;
      set_frame(32'd5, 32'd6, 32'd7, 32'd8);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd5, 32'd6, 65'd61)) begin
         n_bad++;
         $display("FAIL rst_mid_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd5, 32'd6, 65'd61));
      end
      step();   // ch0 handshake done, ch1 now visible
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({act, drop_cnt, overflow} !== exp_z) begin
         n_bad++;
         $display("FAIL rst_mid_zero: got %h expected %h", {act, drop_cnt, overflow}, exp_z);
      end
      step();
      n_cmp++;
      if ({busy, out_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_mid_abandon: got busy/valid %b expected 00", {busy, out_valid});
      end
      set_frame(32'd2, 32'd0, 32'd0, 32'd3);
      step();
      frame_valid_i = 1'b0;
      n_cmp++;
      if (act !== beat(1'b0, 1'b0, 32'd2, 32'd0, 65'd4)) begin
         n_bad++;
         $display("FAIL rst_new_ch0: got %h expected %h", act, beat(1'b0, 1'b0, 32'd2, 32'd0, 65'd4));
      end
      step();
      n_cmp++;
      if (act !== beat(1'b1, 1'b1, 32'd0, 32'd3, 65'd9)) begin
         n_bad++;
         $display("FAIL rst_new_ch1: got %h expected %h", act, beat(1'b1, 1'b1, 32'd0, 32'd3, 65'd9));
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_drop();
      test_extremes();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
